fir_sample_sched: RTL and testbench



---
 rtl/fir_sched_pkg.sv | 20 ++
 rtl/fir_sample_sched_if.sv | 41 ++++
 rtl/fir_rr_arb2.sv | 38 +++
 rtl/fir_sample_sched.sv | 186 ++++++++++++++++++
 tb/tb_fir_sample_sched.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and default widths for the FIR sample scheduler.
//   sched_state_e : scheduler FSM states
//   ch_id_t       : requester channel id (0 or 1)
//   DefDinW       : default FIR input sample width
//   DefDoutW      : default FIR result width
package fir_sched_pkg;

  localparam int unsigned DefDinW  = 6;
  localparam int unsigned DefDoutW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFlush
  } sched_state_e;

  typedef logic ch_id_t;

endpackage

// File: rtl/fir_sample_sched_if.sv
// Handshake bundle for fir_sample_sched.
//   enable/busy            : run control and status
//   chN_data/valid/ready   : requester handshakes (N = 0, 1)
//   fir_tdata/tvalid/tready: issue side towards the FIR core
//   fir_result             : FIR output data
//   out_data/ch/valid      : tagged result strobe
// Modport master is the scheduler side; slave is the surrounding logic.
interface fir_sample_sched_if #(
  parameter int unsigned DIN_W  = 6,
  parameter int unsigned DOUT_W = 8
);

  logic              enable;
  logic              busy;
  logic [DIN_W-1:0]  ch0_data;
  logic              ch0_valid;
  logic              ch0_ready;
  logic [DIN_W-1:0]  ch1_data;
  logic              ch1_valid;
  logic              ch1_ready;
  logic [DIN_W-1:0]  fir_tdata;
  logic              fir_tvalid;
  logic              fir_tready;
  logic [DOUT_W-1:0] fir_result;
  logic [DOUT_W-1:0] out_data;
  logic              out_ch;
  logic              out_valid;

  modport master (
    input  enable, ch0_data, ch0_valid, ch1_data, ch1_valid, fir_result,
    output busy, ch0_ready, ch1_ready, fir_tdata, fir_tvalid, fir_tready,
           out_data, out_ch, out_valid
  );

  modport slave (
    output enable, ch0_data, ch0_valid, ch1_data, ch1_valid, fir_result,
    input  busy, ch0_ready, ch1_ready, fir_tdata, fir_tvalid, fir_tready,
           out_data, out_ch, out_valid
  );

endinterface

// File: rtl/fir_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, reset : clock, asynchronous active-high reset
//   en         : arbitration allowed this cycle
//   req        : request vector, bit N = channel N
//   gnt        : one-hot combinational grant
//   gnt_ch     : index of the granted channel (valid when |gnt)
// The last-grant pointer resets to channel 1 so channel 0 wins first.
module fir_rr_arb2
  import fir_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output ch_id_t     gnt_ch
);

  ch_id_t last_q;

  always_comb begin
    gnt    = 2'b00;
    gnt_ch = 1'b0;
    if (en && (req != 2'b00)) begin
      gnt_ch      = (req == 2'b11) ? ~last_q : req[1];
      gnt[gnt_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt_ch;
    end
  end

endmodule

// File: rtl/fir_sample_sched.sv
// Sample scheduler in front of a shared FIR core.
// Arbitrates two requesters round-robin, issues at most one sample per
// RATE_DIV-cycle slot, and tags each FIR result with its source channel.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fir_sample_sched_if.master (handshakes, FIR side, results)
// Optional: define FIR_FLUSH_EN to push NTAPS-1 zero samples through the FIR
// whenever the granted channel differs from the previously issued one.
module fir_sample_sched
  import fir_sched_pkg::*;
#(
  parameter int unsigned DIN_W    = DefDinW,
  parameter int unsigned DOUT_W   = DefDoutW,
  parameter int unsigned RATE_DIV = 4,
  parameter int unsigned FIR_LAT  = 2,
  parameter int unsigned NTAPS    = 4
) (
  input logic                clk,
  input logic                reset,
  fir_sample_sched_if.master bus
);

  localparam int unsigned CntW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  if (RATE_DIV < 1 || FIR_LAT < 1 || NTAPS < 1) begin : g_param_check
    $error("fir_sample_sched: RATE_DIV, FIR_LAT and NTAPS must be >= 1");
  end

  sched_state_e      state_q;
  logic [CntW-1:0]   cnt_q;
  logic              fir_tvalid_q;
  logic [DIN_W-1:0]  fir_tdata_q;
  logic              fir_tready_q;
  ch_id_t            ch_q;
  logic [FIR_LAT-1:0] tag_vld_q;
  logic [FIR_LAT-1:0] tag_ch_q;
  logic              out_valid_q;
  logic [DOUT_W-1:0] out_data_q;
  ch_id_t            out_ch_q;

  logic             slot;
  logic             grant;
  logic             tags_busy;
  logic             tag_in_vld;
  logic [1:0]       gnt;
  ch_id_t           gnt_ch;
  logic [DIN_W-1:0] sel_data;

`ifdef FIR_FLUSH_EN
  localparam int unsigned FcW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  logic [DIN_W-1:0] data_q;
  logic             prev_vld_q;
  ch_id_t           prev_ch_q;
  logic [FcW-1:0]   flush_cnt_q;
  logic             zero_q;      // current strobe is a flush zero, not a real sample
  assign tag_in_vld = fir_tvalid_q & ~zero_q;
`else
  assign tag_in_vld = fir_tvalid_q;
`endif

  // Gated by reset so ready stays low while reset is held.
  assign slot      = bus.enable && (cnt_q == '0) && !reset;
  assign tags_busy = |tag_vld_q;
  assign grant     = |gnt;
  assign sel_data  = gnt_ch ? bus.ch1_data : bus.ch0_data;

  fir_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (slot && (state_q == StIdle)),
    .req    ({bus.ch1_valid, bus.ch0_valid}),
    .gnt    (gnt),
    .gnt_ch (gnt_ch)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!bus.enable || (cnt_q == CntW'(RATE_DIV - 1))) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      fir_tvalid_q <= 1'b0;
      fir_tdata_q  <= '0;
      ch_q         <= 1'b0;
`ifdef FIR_FLUSH_EN
      data_q       <= '0;
      prev_vld_q   <= 1'b0;
      prev_ch_q    <= 1'b0;
      flush_cnt_q  <= '0;
      zero_q       <= 1'b0;
`endif
    end else begin
      fir_tvalid_q <= 1'b0;
`ifdef FIR_FLUSH_EN
      zero_q       <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (grant) begin
            ch_q <= gnt_ch;
`ifdef FIR_FLUSH_EN
            data_q     <= sel_data;
            prev_vld_q <= 1'b1;
            prev_ch_q  <= gnt_ch;
            if (prev_vld_q && (prev_ch_q != gnt_ch)) begin
              flush_cnt_q <= FcW'(NTAPS - 1);
              state_q     <= StFlush;
            end else begin
              fir_tvalid_q <= 1'b1;
              fir_tdata_q  <= sel_data;
              state_q      <= StIssue;
            end
`else
            fir_tvalid_q <= 1'b1;
            fir_tdata_q  <= sel_data;
            state_q      <= StIssue;
`endif
          end else if (!bus.enable && tags_busy) begin
            state_q <= StDrain;
          end
        end
        StIssue: state_q <= bus.enable ? StIdle : StDrain;
        StDrain: if (!tags_busy) state_q <= StIdle;
`ifdef FIR_FLUSH_EN
        StFlush: begin
          if (slot) begin
            fir_tvalid_q <= 1'b1;
            if (flush_cnt_q != '0) begin
              fir_tdata_q <= '0;
              zero_q      <= 1'b1;
              flush_cnt_q <= flush_cnt_q - 1'b1;
            end else begin
              fir_tdata_q <= data_q;
              state_q     <= StIssue;
            end
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag pipe: entry i is visible i+1 cycles after the issue strobe, so the
  // last entry lines up with the cycle in which fir_result is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_q    <= '0;
      tag_ch_q     <= '0;
      fir_tready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= 1'b0;
    end else begin
      for (int i = FIR_LAT - 1; i > 0; i--) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_ch_q[i]  <= tag_ch_q[i-1];
      end
      tag_vld_q[0] <= tag_in_vld;
      tag_ch_q[0]  <= ch_q;
      fir_tready_q <= bus.enable;
      out_valid_q  <= tag_vld_q[FIR_LAT-1];
      if (tag_vld_q[FIR_LAT-1]) begin
        out_data_q <= bus.fir_result;
        out_ch_q   <= tag_ch_q[FIR_LAT-1];
      end
    end
  end

  assign bus.ch0_ready  = gnt[0];
  assign bus.ch1_ready  = gnt[1];
  assign bus.fir_tvalid = fir_tvalid_q;
  assign bus.fir_tdata  = fir_tdata_q;
  assign bus.fir_tready = fir_tready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.busy       = (state_q != StIdle) || tags_busy;

endmodule

// File: tb/tb_fir_sample_sched.sv
// Directed bench for fir_sample_sched (RATE_DIV=4, FIR_LAT=2, NTAPS=4).
module tb_fir_sample_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fir_sample_sched_if #(.DIN_W(6), .DOUT_W(8)) bus ();

  fir_sample_sched #(
    .DIN_W    (6),
    .DOUT_W   (8),
    .RATE_DIV (4),
    .FIR_LAT  (2),
    .NTAPS    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One row per clock cycle: inputs applied, outputs expected mid-cycle.
  typedef struct {
    logic       en;
    logic       v0;
    logic [5:0] d0;
    logic       v1;
    logic [5:0] d1;
    logic [7:0] res;
    logic       r0;
    logic       r1;
    logic       tv;
    logic [5:0] td;
    logic       trdy;
    logic       ov;
    logic [7:0] od;
    logic       och;
    logic       busy;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [20:0] dut_outs();
    return {bus.ch0_ready, bus.ch1_ready, bus.fir_tvalid, bus.fir_tdata, bus.fir_tready,
            bus.out_valid, bus.out_data, bus.out_ch, bus.busy};
  endfunction

  function automatic logic [20:0] vec_outs(vec_t v);
    return {v.r0, v.r1, v.tv, v.td, v.trdy, v.ov, v.od, v.och, v.busy};
  endfunction

  function automatic logic [7:0] fres(int k);
    return 8'(k * 29 + 3);
  endfunction

  function automatic vec_t mk(logic en, logic [7:0] res, logic r0, logic r1, logic tv,
                              logic [5:0] td, logic trdy, logic ov, logic [7:0] od,
                              logic och, logic busy);
    vec_t v;
    v.en = en; v.v0 = 1'b1; v.d0 = 6'h01; v.v1 = 1'b1; v.d1 = 6'h02; v.res = res;
    v.r0 = r0; v.r1 = r1; v.tv = tv; v.td = td; v.trdy = trdy;
    v.ov = ov; v.od = od; v.och = och; v.busy = busy;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic en, logic v0, logic [5:0] d0, logic v1, logic [5:0] d1,
                       logic [7:0] res);
    bus.enable = en; bus.ch0_valid = v0; bus.ch0_data = d0;
    bus.ch1_valid = v1; bus.ch1_data = d1; bus.fir_result = res;
  endtask

  // Leaves the bench at posedge+1 with reset released; the caller drives cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 6'h00, 1'b0, 6'h00, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [5:0] tq[$];
    logic       oq[$];

    //            en  res    r0 r1 tv td     trdy ov od     och busy
    vecs[0]  = mk(1, 8'h10, 1, 0, 0, 6'h00, 0,   0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 8'h11, 0, 0, 1, 6'h01, 1,   0, 8'h00, 0, 1);
    vecs[2]  = mk(1, 8'h12, 0, 0, 0, 6'h01, 1,   0, 8'h00, 0, 1);
    vecs[3]  = mk(1, 8'hA3, 0, 0, 0, 6'h01, 1,   0, 8'h00, 0, 1);
    vecs[4]  = mk(1, 8'h14, 0, 1, 0, 6'h01, 1,   1, 8'hA3, 0, 0);
    vecs[5]  = mk(1, 8'h15, 0, 0, 1, 6'h02, 1,   0, 8'hA3, 0, 1);
    vecs[6]  = mk(1, 8'h16, 0, 0, 0, 6'h02, 1,   0, 8'hA3, 0, 1);
    vecs[7]  = mk(1, 8'h5C, 0, 0, 0, 6'h02, 1,   0, 8'hA3, 0, 1);
    vecs[8]  = mk(1, 8'h18, 1, 0, 0, 6'h02, 1,   1, 8'h5C, 1, 0);
    vecs[9]  = mk(0, 8'h19, 0, 0, 1, 6'h01, 1,   0, 8'h5C, 1, 1);
    vecs[10] = mk(0, 8'h1A, 0, 0, 0, 6'h01, 0,   0, 8'h5C, 1, 1);
    vecs[11] = mk(0, 8'hC7, 0, 0, 0, 6'h01, 0,   0, 8'h5C, 1, 1);
    vecs[12] = mk(0, 8'h1C, 0, 0, 0, 6'h01, 0,   1, 8'hC7, 0, 1);
    vecs[13] = mk(1, 8'h1D, 0, 1, 0, 6'h01, 0,   0, 8'hC7, 0, 0);
    vecs[14] = mk(1, 8'h1E, 0, 0, 1, 6'h02, 1,   0, 8'hC7, 0, 1);

    // Reset held with every input active: all outputs low.
    drive(1'b1, 1'b1, 6'h3F, 1'b1, 6'h3F, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(dut_outs()), 32'h0);
    drive(1'b1, 1'b0, 6'h00, 1'b0, 6'h00, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_after_reset", {30'h0, bus.busy, bus.fir_tvalid}, 32'h0);
      @(posedge clk);
      #1;
    end

    // Cycle-by-cycle trace: alternation, enable drop/drain, re-enable.
    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].res);
      @(negedge clk);
      check($sformatf("trace_row%0d", i), 32'(dut_outs()), 32'(vec_outs(vecs[i])));
      @(posedge clk);
      #1;
    end

    // Single requester streaming: one issue per 4-cycle slot.
    do_reset();
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, 1'b1, 6'h15, 1'b0, 6'h00, fres(k));
      @(negedge clk);
      check($sformatf("stream_k%0d_ready", k), {30'h0, bus.ch0_ready, bus.ch1_ready},
            {30'h0, (k % 4 == 0), 1'b0});
      check($sformatf("stream_k%0d_tvalid", k), {31'h0, bus.fir_tvalid},
            {31'h0, (k % 4 == 1)});
      if (k % 4 == 1) check("stream_tdata", 32'(bus.fir_tdata), 32'h15);
      check($sformatf("stream_k%0d_ovalid", k), {31'h0, bus.out_valid},
            {31'h0, (k >= 4 && k % 4 == 0)});
      if (k >= 4 && k % 4 == 0) begin
        check("stream_odata", 32'(bus.out_data), 32'(fres(k - 1)));
        check("stream_och", 32'(bus.out_ch), 32'h0);
      end
      @(posedge clk);
      #1;
    end

    // Reset during an issue strobe: the sample never produces a result.
    do_reset();
    drive(1'b1, 1'b1, 6'h0A, 1'b0, 6'h00, 8'h66);
    @(posedge clk);
    #1 bus.ch0_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_tvalid", {31'h0, bus.fir_tvalid}, 32'h1);
    reset = 1'b1;
    #1;
    check("async_reset_clears", {29'h0, bus.fir_tvalid, bus.busy, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_result_after_reset", {30'h0, bus.out_valid, bus.busy}, 32'h0);
      @(posedge clk);
      #1;
    end

`ifdef FIR_FLUSH_EN
    // Channel change: three zero strobes before the ch1 sample, no extra results.
    do_reset();
    for (int k = 0; k < 28; k++) begin
      drive(1'b1, (k == 0), 6'h15, (k == 4), 6'h2A, fres(k));
      @(negedge clk);
      if (bus.fir_tvalid) tq.push_back(bus.fir_tdata);
      if (bus.out_valid) oq.push_back(bus.out_ch);
      @(posedge clk);
      #1;
    end
    check("flush_strobes", 32'(tq.size()), 32'd5);
    if (tq.size() == 5) begin
      check("flush_s0", 32'(tq[0]), 32'h15);
      check("flush_s1", 32'(tq[1]), 32'h00);
      check("flush_s2", 32'(tq[2]), 32'h00);
      check("flush_s3", 32'(tq[3]), 32'h00);
      check("flush_s4", 32'(tq[4]), 32'h2A);
    end
    check("flush_results", 32'(oq.size()), 32'd2);
    if (oq.size() == 2) begin
      check("flush_och0", 32'(oq[0]), 32'h0);
      check("flush_och1", 32'(oq[1]), 32'h1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
